// File: rtl/sys_addr_dec_if.sv
// sys_addr_dec_if: bus-side access and read-select signals of the
// system address decoder.
interface sys_addr_dec_if #(
  parameter int NUM_SLV = 3,
  parameter int SEL_W   = 2
);
  logic               req;
  logic               WE;
  logic [31:0]        A;
  logic [NUM_SLV-1:0] WES;
  logic [SEL_W-1:0]   RdSel;
  logic               rd_valid;

  modport master (
    output req, WE, A,
    input  WES, RdSel, rd_valid
  );

  modport slave (
    input  req, WE, A,
    output WES, RdSel, rd_valid
  );
endinterface

// File: rtl/sys_addr_dec.sv
// sys_addr_dec: region decoder with write enables, read-select pipeline and
// sticky miss capture; SYS_ADDR_DEC_ERRCNT_EN adds a saturating miss counter.
module sys_addr_dec #(
  parameter int NUM_SLV = 3,
  parameter int SEL_W   = 2,
  parameter logic [NUM_SLV*32-1:0] BASE =
    {32'h900, 32'h800, 32'h000},
  parameter logic [NUM_SLV*32-1:0] LIMIT =
    {32'h90C, 32'h80C, 32'h0FC},
  parameter int RD_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  sys_addr_dec_if.slave bus,
  input  logic        err_clr,
  output logic        err,
  output logic [31:0] err_addr,
  output logic [15:0] err_cnt
);

  logic [NUM_SLV-1:0] win;
  logic [SEL_W-1:0]   code;
  logic               found;
  logic               rd;
  logic               miss;

  // Ascending scan so the lowest hitting region wins on overlap.
  always_comb begin
    win   = '0;
    code  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (!found &&
          bus.A >= BASE[32*k +: 32] &&
          bus.A <= LIMIT[32*k +: 32]) begin
        found  = 1'b1;
        code   = SEL_W'(k);
        win[k] = 1'b1;
      end
    end
  end

  assign bus.WES = (bus.req & bus.WE) ? win : '0;
  assign rd      = bus.req & ~bus.WE;
  assign miss    = bus.req & ~found;

  logic [SEL_W-1:0]  code_q [RD_LAT];
  logic [RD_LAT-1:0] vld_q;

  // Codes only advance behind a valid, so RdSel holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++)
        code_q[i] <= '0;
    end else begin
      vld_q[0] <= rd;
      if (rd)
        code_q[0] <= code;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1])
          code_q[i] <= code_q[i-1];
      end
    end
  end

  assign bus.RdSel    = code_q[RD_LAT-1];
  assign bus.rd_valid = vld_q[RD_LAT-1];

  // A miss beats a simultaneous clear and restarts the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (miss && (!err || err_clr)) begin
      err      <= 1'b1;
      err_addr <= bus.A;
    end else if (err_clr) begin
      err      <= 1'b0;
      err_addr <= '0;
    end
  end

`ifdef SYS_ADDR_DEC_ERRCNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (miss) begin
      if (err_clr)
        cnt_q <= 16'd1;
      else if (cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end else if (err_clr) begin
      cnt_q <= '0;
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
